// File: rtl/nd_2to1_arb.sv
// nd_2to1_arb: two-input round-robin arbiter sharing one 4-phase message
// channel (o0) between requesters i0 and i1.
//
// The granted message is captured into a single buffer register and the
// requester is released before the message is forwarded on o0.
//
// Optional feature, macro NS_ARB_REDUN_CHK_EN:
//   When defined, a CHECK state recomputes the redundancy field of the
//   buffered message. Corrupted messages are dropped and a sticky error flag
//   is set.
//   When undefined, every message is forwarded and err reads 0.
`timescale 1ns/1ps

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module nd_2to1_arb #(
   parameter int ASZ         = `NS_ADDRESS_SIZE,
   parameter int DSZ         = `NS_DATA_SIZE,
   parameter int RSZ         = `NS_REDUN_SIZE,
   parameter bit FIRST_GRANT = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [ASZ-1:0] i0_src,
   input  logic [ASZ-1:0] i0_dst,
   input  logic [DSZ-1:0] i0_dat,
   input  logic [RSZ-1:0] i0_red,
   input  logic           i0_req,
   output logic           i0_ack,
   input  logic [ASZ-1:0] i1_src,
   input  logic [ASZ-1:0] i1_dst,
   input  logic [DSZ-1:0] i1_dat,
   input  logic [RSZ-1:0] i1_red,
   input  logic           i1_req,
   output logic           i1_ack,
   output logic [ASZ-1:0] o0_src,
   output logic [ASZ-1:0] o0_dst,
   output logic [DSZ-1:0] o0_dat,
   output logic [RSZ-1:0] o0_red,
   output logic           o0_req,
   input  logic           o0_ack,
   output logic           last_grant,
   output logic           busy,
   output logic [3:0]     dbg_leds
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_IREL,
`ifdef NS_ARB_REDUN_CHK_EN
      ST_CHECK,
`endif
      ST_SEND,
      ST_OREL
   } state_t;

   typedef struct packed {
      logic [ASZ-1:0] src;
      logic [ASZ-1:0] dst;
      logic [DSZ-1:0] dat;
      logic [RSZ-1:0] red;
   } msg_t;

   state_t state;
   msg_t   msg_buf;
   logic   err;
   logic   want0;
   logic   want1;
   logic   pick;
   logic   granted_req;

   // A requester is eligible while it asks and has not yet been acknowledged.
   assign want0 = i0_req & ~i0_ack;
   assign want1 = i1_req & ~i1_ack;

   // On a tie the input that did not win last time goes next; otherwise the
   // lone requester wins. last_grant doubles as the in-flight selector,
   // because it only changes when a new grant is made in IDLE.
   assign pick        = (want0 & want1) ? ~last_grant : want1;
   assign granted_req = last_grant ? i1_req : i0_req;

`ifdef NS_ARB_REDUN_CHK_EN
   logic [RSZ-1:0] red_calc;

   calc_redun #(
      .ASZ (ASZ),
      .DSZ (DSZ),
      .RSZ (RSZ)
   ) u_calc_redun (
      .src (msg_buf.src),
      .dst (msg_buf.dst),
      .dat (msg_buf.dat),
      .red (red_calc)
   );
`else
   assign err = 1'b0;
`endif

   // Arbitration FSM: grant, capture, release input, forward, release output.
   // NOTE: every register here uses non-blocking assignment so that all state
   // updates in one clock edge see the values from before that edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         last_grant <= ~FIRST_GRANT;
         i0_ack     <= 1'b0;
         i1_ack     <= 1'b0;
         o0_req     <= 1'b0;
         // NOTE: the buffer is reset along with the control state. It drives
         // o0_* directly, and those outputs must read 0 out of reset.
         msg_buf    <= '0;
`ifdef NS_ARB_REDUN_CHK_EN
         err        <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (want0 | want1) begin
                  last_grant <= pick;
                  state      <= ST_CAPTURE;
               end
            end

            ST_CAPTURE: begin
               if (last_grant) begin
                  msg_buf <= {i1_src, i1_dst, i1_dat, i1_red};
                  i1_ack  <= 1'b1;
               end else begin
                  msg_buf <= {i0_src, i0_dst, i0_dat, i0_red};
                  i0_ack  <= 1'b1;
               end
               state <= ST_IREL;
            end

            ST_IREL: begin
               if (!granted_req) begin
                  i0_ack <= 1'b0;
                  i1_ack <= 1'b0;
`ifdef NS_ARB_REDUN_CHK_EN
                  state  <= ST_CHECK;
`else
                  o0_req <= 1'b1;
                  state  <= ST_SEND;
`endif
               end
            end

`ifdef NS_ARB_REDUN_CHK_EN
            ST_CHECK: begin
               if (red_calc == msg_buf.red) begin
                  o0_req <= 1'b1;
                  state  <= ST_SEND;
               end else begin
                  err    <= 1'b1;
                  state  <= ST_IDLE;
               end
            end
`endif

            ST_SEND: begin
               if (o0_ack) begin
                  o0_req <= 1'b0;
                  state  <= ST_OREL;
               end
            end

            ST_OREL: begin
               if (!o0_ack) state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   // The buffer is presented on o0_* unchanged; it only reloads in CAPTURE,
   // so the fields stay stable for the whole of SEND.
   assign o0_src   = msg_buf.src;
   assign o0_dst   = msg_buf.dst;
   assign o0_dat   = msg_buf.dat;
   assign o0_red   = msg_buf.red;

   assign busy     = (state != ST_IDLE);
   assign dbg_leds = {1'b0, busy, last_grant, err};

endmodule

`ifdef NS_ARB_REDUN_CHK_EN
// calc_redun: redundancy code, the sum of src, dst and dat modulo 2**RSZ.
module calc_redun #(
   parameter int ASZ = 8,
   parameter int DSZ = 16,
   parameter int RSZ = 8
) (
   input  logic [ASZ-1:0] src,
   input  logic [ASZ-1:0] dst,
   input  logic [DSZ-1:0] dat,
   output logic [RSZ-1:0] red
);
   // Truncating each term before adding gives the same low bits as a full sum.
   assign red = RSZ'(src) + RSZ'(dst) + RSZ'(dat);
endmodule
`endif

// File: tb/tb_nd_2to1_arb.sv
// tb_nd_2to1_arb: directed scoreboard bench for nd_2to1_arb.
// Expected o0 messages are queued in delivery order when stimulus is issued.
// A monitor pops and compares them on every o0_req rise.
`timescale 1ns/1ps

module tb_nd_2to1_arb;

   localparam int ASZ = 8;
   localparam int DSZ = 16;
   localparam int RSZ = 8;
`ifdef NS_ARB_REDUN_CHK_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   typedef struct packed {
      logic [ASZ-1:0] src;
      logic [ASZ-1:0] dst;
      logic [DSZ-1:0] dat;
      logic [RSZ-1:0] red;
   } msg_t;

   typedef struct {
      msg_t m;
      bit   idx;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [ASZ-1:0] i0_src = '0, i0_dst = '0, i1_src = '0, i1_dst = '0;
   logic [DSZ-1:0] i0_dat = '0, i1_dat = '0;
   logic [RSZ-1:0] i0_red = '0, i1_red = '0;
   logic           i0_req = 1'b0, i1_req = 1'b0;
   logic           i0_ack, i1_ack;
   logic [ASZ-1:0] o0_src, o0_dst;
   logic [DSZ-1:0] o0_dat;
   logic [RSZ-1:0] o0_red;
   logic           o0_req;
   logic           o0_ack = 1'b0;
   logic           last_grant, busy;
   logic [3:0]     dbg_leds;

   exp_t exp_q[$];
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   ds_wait = 0;

   nd_2to1_arb #(
      .ASZ         (ASZ),
      .DSZ         (DSZ),
      .RSZ         (RSZ),
      .FIRST_GRANT (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i0_src     (i0_src),
      .i0_dst     (i0_dst),
      .i0_dat     (i0_dat),
      .i0_red     (i0_red),
      .i0_req     (i0_req),
      .i0_ack     (i0_ack),
      .i1_src     (i1_src),
      .i1_dst     (i1_dst),
      .i1_dat     (i1_dat),
      .i1_red     (i1_red),
      .i1_req     (i1_req),
      .i1_ack     (i1_ack),
      .o0_src     (o0_src),
      .o0_dst     (o0_dst),
      .o0_dat     (o0_dat),
      .o0_red     (o0_red),
      .o0_req     (o0_req),
      .o0_ack     (o0_ack),
      .last_grant (last_grant),
      .busy       (busy),
      .dbg_leds   (dbg_leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Message with a correct redundancy field: (src + dst + dat) mod 256.
   function automatic msg_t mk(input int src, input int dst, input int dat);
      msg_t m;
      m.src = ASZ'(src);
      m.dst = ASZ'(dst);
      m.dat = DSZ'(dat);
      m.red = RSZ'((src + dst + dat) % 256);
      return m;
   endfunction

   function automatic exp_t ex(input bit idx, input msg_t m);
      exp_t e;
      e.m   = m;
      e.idx = idx;
      return e;
   endfunction

   // 4-phase sender for one input; starts at a negedge.
   task automatic send(input bit idx, input msg_t m);
      int t;
      if (idx) begin
         {i1_src, i1_dst, i1_dat, i1_red} = m;
         i1_req = 1'b1;
      end else begin
         {i0_src, i0_dst, i0_dat, i0_red} = m;
         i0_req = 1'b1;
      end
      t = 0;
      while (!(idx ? i1_ack : i0_ack) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check(idx ? "i1_ack_rise" : "i0_ack_rise", {63'd0, idx ? i1_ack : i0_ack}, 64'd1);
      if (idx) i1_req = 1'b0; else i0_req = 1'b0;
      t = 0;
      while ((idx ? i1_ack : i0_ack) && t < 400) begin
         @(negedge clk);
         t++;
      end
      check(idx ? "i1_ack_fall" : "i0_ack_fall", {63'd0, idx ? i1_ack : i0_ack}, 64'd0);
   endtask

   // Wait until every queued message is delivered and all handshakes are idle.
   task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || busy || o0_ack || i0_req || i1_req || i0_ack || i1_ack)
             && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      check("drain_busy", {63'd0, busy}, 64'd0);
   endtask

   task automatic wait_o0_req();
      int t = 0;
      while (!o0_req && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("o0_req_wait", {63'd0, o0_req}, 64'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Downstream responder: acks after ds_wait cycles, then completes the 4-phase.
   initial begin
      int t;
      forever begin
         @(negedge clk);
         if (o0_req && !o0_ack) begin
            repeat (ds_wait) @(negedge clk);
            o0_ack = 1'b1;
            t = 0;
            while (o0_req && t < 1000) begin
               @(negedge clk);
               t++;
            end
            if (o0_req) check("o0_req_release", {63'd0, o0_req}, 64'd0);
            o0_ack = 1'b0;
         end
      end
   end

   // Monitor: compare each presented message against the scoreboard head.
   initial begin
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (o0_req && !prev) begin
            if (exp_q.size() == 0) begin
               check("o0_unexpected_req", {63'd0, o0_req}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("o0_msg", 64'({o0_src, o0_dst, o0_dat, o0_red}), 64'(e.m));
               check("o0_grant_src", {63'd0, last_grant}, {63'd0, e.idx});
            end
         end
         prev = o0_req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      msg_t m;
      msg_t hold_m;

      // Reset state.
      do_reset();
      check("rst_o0_req", {63'd0, o0_req}, 64'd0);
      check("rst_acks", {62'd0, i0_ack, i1_ack}, 64'd0);
      check("rst_o0_fields", 64'({o0_src, o0_dst, o0_dat, o0_red}), 64'd0);
      check("rst_dbg_leds", {60'd0, dbg_leds}, 64'h2);
      check("rst_last_grant", {63'd0, last_grant}, 64'd1);

      // Single i0 message: latency and handshake ordering.
      m = mk(9, 1, 3);
      exp_q.push_back(ex(1'b0, m));
      fork
         send(1'b0, m);
         begin
            repeat (2) @(negedge clk);
            check("t1_ack_high", {63'd0, i0_ack}, 64'd1);
            check("t1_o0_req_early", {63'd0, o0_req}, 64'd0);
            repeat (LAT - 1) @(negedge clk);
            check("t1_o0_req_rise", {63'd0, o0_req}, 64'd1);
            check("t1_ack_done", {63'd0, i0_ack}, 64'd0);
            check("t1_last_grant", {63'd0, last_grant}, 64'd0);
            check("t1_busy", {63'd0, busy}, 64'd1);
         end
      join
      wait_idle();

      // Simultaneous requests, 4 per input, from reset: strict alternation.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(ex(1'b0, mk(8'h10 + k, 2, 16'h100 + k)));
         exp_q.push_back(ex(1'b1, mk(8'h20 + k, 3, 16'h200 + k)));
      end
      fork
         begin
            for (int k = 0; k < 4; k++) send(1'b0, mk(8'h10 + k, 2, 16'h100 + k));
         end
         begin
            for (int k = 0; k < 4; k++) send(1'b1, mk(8'h20 + k, 3, 16'h200 + k));
         end
      join
      wait_idle();

      // i1 streams 16 messages back to back with i0 idle.
      for (int k = 0; k < 16; k++) exp_q.push_back(ex(1'b1, mk(5, 7, k)));
      for (int k = 0; k < 16; k++) send(1'b1, mk(5, 7, k));
      wait_idle();

      // Downstream stalls 20 cycles: o0 held stable, waiting i0 not acked.
      ds_wait = 20;
      hold_m  = mk(8'h33, 8'h44, 16'hbeef);
      exp_q.push_back(ex(1'b1, hold_m));
      exp_q.push_back(ex(1'b0, mk(8'h55, 8'h66, 16'h1234)));
      fork
         send(1'b1, hold_m);
      join_none
      wait_o0_req();
      fork
         send(1'b0, mk(8'h55, 8'h66, 16'h1234));
      join_none
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("stall_hold", 64'({o0_req, i0_ack, o0_src, o0_dst, o0_dat, o0_red}),
               64'({1'b1, 1'b0, hold_m}));
      end
      wait_idle();
      ds_wait = 0;

      // Reset asserted during SEND, then a normal i1 message.
      ds_wait = 10;
      exp_q.push_back(ex(1'b1, mk(1, 2, 16'h0abc)));
      send(1'b1, mk(1, 2, 16'h0abc));
      wait_o0_req();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_mid_o0_req", {63'd0, o0_req}, 64'd0);
      check("rst_mid_acks", {62'd0, i0_ack, i1_ack}, 64'd0);
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_buf", 64'({o0_src, o0_dst, o0_dat, o0_red}), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ds_wait = 0;
      repeat (15) @(negedge clk);
      exp_q.push_back(ex(1'b1, mk(8'h77, 8'h88, 16'h4242)));
      send(1'b1, mk(8'h77, 8'h88, 16'h4242));
      wait_idle();

`ifdef NS_ARB_REDUN_CHK_EN
      // Corrupted redundancy: acked, dropped, sticky error; next message passes.
      m = mk(4, 5, 6);
      m.red = m.red + 1'b1;
      send(1'b0, m);
      repeat (6) @(negedge clk);
      check("redun_err_led", {63'd0, dbg_leds[0]}, 64'd1);
      check("redun_no_send", {62'd0, o0_req, busy}, 64'd0);
      exp_q.push_back(ex(1'b1, mk(8'h11, 8'h22, 16'h0033)));
      send(1'b1, mk(8'h11, 8'h22, 16'h0033));
      wait_idle();
      check("redun_err_sticky", {63'd0, dbg_leds[0]}, 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
